// File: rtl/qproc_time_cmd_arb_if.sv
// Requester/time-control bundle for the time command arbiter.
// The master side drives requests and acks; the slave side is the arbiter itself.
interface qproc_time_cmd_arb_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 32
);
    logic [N_REQ-1:0]    req_vld_i;
    logic [4*N_REQ-1:0]  req_cmd_i;
    logic [DW*N_REQ-1:0] req_dt_i;
    logic [N_REQ-1:0]    req_rdy_o;
    logic                tc_en_o;
    logic [3:0]          tc_cmd_o;
    logic [DW-1:0]       tc_dt_o;
    logic                tc_ack_i;
    logic [2:0]          grant_id_o;
    logic                busy_o;
    logic                err_to_o;
    logic                err_clr_i;
    logic [1:0]          st_do;

    modport master (
        output req_vld_i, req_cmd_i, req_dt_i, tc_ack_i, err_clr_i,
        input  req_rdy_o, tc_en_o, tc_cmd_o, tc_dt_o, grant_id_o, busy_o, err_to_o, st_do
    );

    modport slave (
        input  req_vld_i, req_cmd_i, req_dt_i, tc_ack_i, err_clr_i,
        output req_rdy_o, tc_en_o, tc_cmd_o, tc_dt_o, grant_id_o, busy_o, err_to_o, st_do
    );
endinterface

// File: rtl/qproc_time_cmd_arb.sv
// Time-command arbiter: reset commands win, everything else round-robin; one command in flight,
// each followed by an ack wait (with timeout) and a HOLD-cycle idle gap.
module qproc_time_cmd_arb #(
    parameter int N_REQ  = 4,
    parameter int DW     = 32,
    parameter int HOLD   = 2,
    parameter int ACK_TO = 255
) (
    input  logic                  c_clk_i,
    input  logic                  c_rst_ni,
    qproc_time_cmd_arb_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT = 2'd2, S_GAP = 2'd3} state_e;

    localparam state_e     DONE_ST  = (HOLD == 0) ? S_IDLE : S_GAP;
    localparam logic [3:0] GAP_LAST = 4'((HOLD == 0) ? 0 : HOLD - 1);
    localparam logic [9:0] TO_LAST  = 10'(ACK_TO - 1);

    state_e            state_q, state_d;
    logic [2:0]        rr_q, rr_d;
    logic [9:0]        to_q, to_d;
    logic [3:0]        gap_q, gap_d;
    logic [2:0]        gid_q, gid_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [DW-1:0]     dt_q, dt_d;
    logic [N_REQ-1:0]  rdy_q, rdy_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic [7:0]        vld8, rst8;
    logic              rst_hit;
    logic [3:0]        idx;
    logic [2:0]        gnt;
    logic [3:0]        sel_cmd;
    logic [DW-1:0]     sel_dt;

    // Grant pick: lowest-index reset request, else first valid starting at rr_q.
    always_comb begin
        vld8    = '0;
        rst8    = '0;
        rst_hit = 1'b0;
        gnt     = '0;
        idx     = '0;
        sel_cmd = '0;
        sel_dt  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            vld8[i] = bus.req_vld_i[i];
            rst8[i] = bus.req_vld_i[i] & bus.req_cmd_i[4*i];
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rst8[i]) begin
                rst_hit = 1'b1;
                gnt     = 3'(i);
            end
        end
        if (!rst_hit) begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                idx = 4'(rr_q) + 4'(k);
                if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
                if (vld8[idx[2:0]]) gnt = idx[2:0];
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt == 3'(i)) begin
                sel_cmd = bus.req_cmd_i[4*i +: 4];
                sel_dt  = bus.req_dt_i[DW*i +: DW];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        to_d    = to_q;
        gap_d   = gap_q;
        gid_d   = gid_q;
        cmd_d   = cmd_q;
        dt_d    = dt_q;
        rdy_d   = '0;
        en_d    = 1'b0;
        err_d   = err_q;
        if (bus.err_clr_i) err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|bus.req_vld_i) begin
                    gid_d = gnt;
                    cmd_d = sel_cmd;
                    dt_d  = sel_dt;
                    rr_d  = (gnt == 3'(N_REQ - 1)) ? 3'd0 : gnt + 3'd1;
                    for (int i = 0; i < N_REQ; i++) rdy_d[i] = (gnt == 3'(i));
                    en_d    = (sel_cmd != 4'd0);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_d  = '0;
                gap_d = '0;
                // An all-zero command is accepted but never reaches time control.
                state_d = (cmd_q != 4'd0) ? S_WAIT : DONE_ST;
            end
            S_WAIT: begin
                if (bus.tc_ack_i) begin
                    state_d = DONE_ST;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = DONE_ST;
                end else begin
                    to_d = to_q + 10'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) state_d = S_IDLE;
                else                   gap_d   = gap_q + 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge c_clk_i or negedge c_rst_ni) begin
        if (!c_rst_ni) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            to_q    <= '0;
            gap_q   <= '0;
            gid_q   <= '0;
            cmd_q   <= '0;
            dt_q    <= '0;
            rdy_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            to_q    <= to_d;
            gap_q   <= gap_d;
            gid_q   <= gid_d;
            cmd_q   <= cmd_d;
            dt_q    <= dt_d;
            rdy_q   <= rdy_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_rdy_o  = rdy_q;
    assign bus.tc_en_o    = en_q;
    assign bus.tc_cmd_o   = cmd_q;
    assign bus.tc_dt_o    = dt_q;
    assign bus.grant_id_o = gid_q;
    assign bus.busy_o     = busy_q;
    assign bus.err_to_o   = err_q;
    assign bus.st_do      = state_q;
endmodule

// File: tb/tb_qproc_time_cmd_arb.sv
// Bench for qproc_time_cmd_arb: transaction-level model compared every cycle, plus directed
// scenarios with literal expectations on grant order, latencies and the timeout flag.
module tb_qproc_time_cmd_arb;
    localparam int N_REQ  = 4;
    localparam int DW     = 32;
    localparam int HOLD   = 2;
    localparam int ACK_TO = 255;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    qproc_time_cmd_arb_if #(.N_REQ(N_REQ), .DW(DW)) ifc ();

    qproc_time_cmd_arb #(.N_REQ(N_REQ), .DW(DW), .HOLD(HOLD), .ACK_TO(ACK_TO)) dut (
        .c_clk_i  (clk),
        .c_rst_ni (rst_n),
        .bus      (ifc.slave)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    endtask

    // Requester bookkeeping: stimulus posts requests, requester process retires them on rdy.
    int post_cnt [N_REQ];
    int acc_cnt  [N_REQ];
    int ack_dly  = 3;
    logic stray_ack = 1'b0;
    int gq[$];

    initial begin
        logic [N_REQ-1:0] rdy_seen;
        rdy_seen = '0;
        for (int k = 0; k < N_REQ; k++) acc_cnt[k] = 0;
        ifc.req_vld_i = '0;
        forever begin
            @(posedge clk); #2;
            for (int k = 0; k < N_REQ; k++) if (rdy_seen[k]) acc_cnt[k]++;
            rdy_seen = ifc.req_rdy_o;
            for (int k = 0; k < N_REQ; k++) ifc.req_vld_i[k] = (post_cnt[k] != acc_cnt[k]);
        end
    end

    initial begin
        int cd;
        logic pulse;
        cd = 0;
        ifc.tc_ack_i = 1'b0;
        forever begin
            @(posedge clk); #2;
            pulse = 1'b0;
            if (cd > 0) begin
                cd--;
                pulse = (cd == 0);
            end else if (ifc.tc_en_o && ack_dly > 0) begin
                cd = ack_dly;
            end
            ifc.tc_ack_i = pulse | stray_ack;
        end
    end

    // Behavioural model: phase 0 idle, 1 issue, 2 waiting for ack, 3 gap.
    logic [N_REQ-1:0] e_rdy = '0;
    logic             e_en = 1'b0, e_busy = 1'b0, e_err = 1'b0;
    logic [3:0]       e_cmd = '0;
    logic [DW-1:0]    e_dt = '0;
    logic [2:0]       e_gid = '0;
    int m_ph = 0, m_rr = 0, m_age = 0, m_gap = 0, m_g = 0;
    logic m_to;

    function automatic int pick(input logic [N_REQ-1:0] v, input logic [4*N_REQ-1:0] c, input int rr);
        for (int i = 0; i < N_REQ; i++) if (v[i] && c[4*i]) return i;
        for (int k = 0; k < N_REQ; k++) if (v[(rr + k) % N_REQ]) return (rr + k) % N_REQ;
        return 0;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = 0; m_rr = 0; m_age = 0; m_gap = 0;
                e_rdy = '0; e_en = 0; e_busy = 0; e_err = 0; e_cmd = '0; e_dt = '0; e_gid = '0;
            end else begin
                e_rdy = '0;
                e_en  = 1'b0;
                m_to  = 1'b0;
                case (m_ph)
                    0: if (|ifc.req_vld_i) begin
                        m_g   = pick(ifc.req_vld_i, ifc.req_cmd_i, m_rr);
                        e_gid = 3'(m_g);
                        e_cmd = ifc.req_cmd_i[4*m_g +: 4];
                        e_dt  = ifc.req_dt_i[DW*m_g +: DW];
                        e_rdy[m_g] = 1'b1;
                        e_en  = (e_cmd != 0);
                        m_rr  = (m_g + 1) % N_REQ;
                        m_ph  = 1;
                    end
                    1: if (e_cmd != 0) begin
                        m_ph = 2; m_age = 0;
                    end else begin
                        m_ph = (HOLD == 0) ? 0 : 3; m_gap = HOLD;
                    end
                    2: if (ifc.tc_ack_i || m_age == ACK_TO - 1) begin
                        m_to = !ifc.tc_ack_i;
                        m_ph = (HOLD == 0) ? 0 : 3; m_gap = HOLD;
                    end else m_age++;
                    default: begin
                        m_gap--;
                        if (m_gap == 0) m_ph = 0;
                    end
                endcase
                if (ifc.err_clr_i) e_err = 1'b0;
                if (m_to) e_err = 1'b1;
                e_busy = (m_ph != 0);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            chk("rdy", 64'(ifc.req_rdy_o), 64'(e_rdy));
            chk("tc_en", 64'(ifc.tc_en_o), 64'(e_en));
            chk("tc_cmd", 64'(ifc.tc_cmd_o), 64'(e_cmd));
            chk("tc_dt", 64'(ifc.tc_dt_o), 64'(e_dt));
            chk("grant_id", 64'(ifc.grant_id_o), 64'(e_gid));
            chk("busy", 64'(ifc.busy_o), 64'(e_busy));
            chk("err_to", 64'(ifc.err_to_o), 64'(e_err));
            chk("st", 64'(ifc.st_do), 64'(m_ph));
            for (int k = 0; k < N_REQ; k++) if (ifc.req_rdy_o[k]) gq.push_back(k);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic post(input int k, input logic [3:0] c, input logic [DW-1:0] d, input int times);
        ifc.req_cmd_i[4*k +: 4] = c;
        ifc.req_dt_i[DW*k +: DW] = d;
        post_cnt[k] += times;
    endtask

    function automatic bit all_done();
        for (int k = 0; k < N_REQ; k++) if (post_cnt[k] != acc_cnt[k]) return 1'b0;
        return !ifc.busy_o;
    endfunction

    function automatic int gq_at(input int i);
        return (i < gq.size()) ? gq[i] : 7;
    endfunction

    task automatic settle(input string nm, input int budget);
        int c;
        c = 0;
        while (!all_done() && c < budget) begin cyc(1); c++; end
        chk(nm, 64'(c < budget), 64'd1);
    endtask

    task automatic wait_rdy(input string nm, input int k);
        int c;
        c = 0;
        while (!ifc.req_rdy_o[k] && c < 50) begin cyc(1); c++; end
        chk(nm, 64'(ifc.req_rdy_o[k]), 64'd1);
    endtask

    task automatic busy_len(input string nm, input int exp);
        int c;
        c = 0;
        while (ifc.busy_o && c < 40) begin cyc(1); c++; end
        chk(nm, 64'(c), 64'(exp));
    endtask

    initial begin
        int base, c;
        for (int k = 0; k < N_REQ; k++) post_cnt[k] = 0;
        rst_n = 1'b0;
        ifc.req_cmd_i = '0;
        ifc.req_dt_i = '0;
        ifc.err_clr_i = 1'b0;
        cyc(3);
        chk("rst_st", 64'(ifc.st_do), 64'd0);
        chk("rst_busy", 64'(ifc.busy_o), 64'd0);
        chk("rst_err", 64'(ifc.err_to_o), 64'd0);
        chk("rst_rdy", 64'(ifc.req_rdy_o), 64'd0);
        rst_n = 1'b1;
        cyc(2);

        // Reset command beats round-robin: rr_ptr=0, yet req3 goes first.
        base = gq.size();
        post(0, 4'b0010, 32'hA0, 1);
        post(3, 4'b0001, 32'hD3, 1);
        settle("t3_settle", 100);
        chk("t3_first", 64'(gq_at(base)), 64'd3);
        chk("t3_second", 64'(gq_at(base + 1)), 64'd0);

        // Single update on req1, ack 3 cycles after strobe, then HOLD gap.
        post(1, 4'b0010, 32'h100, 1);
        wait_rdy("t1_rdy_seen", 1);
        chk("t1_rdy", 64'(ifc.req_rdy_o), 64'b0010);
        chk("t1_en", 64'(ifc.tc_en_o), 64'd1);
        chk("t1_dt", 64'(ifc.tc_dt_o), 64'h100);
        chk("t1_gid", 64'(ifc.grant_id_o), 64'd1);
        busy_len("t1_busy_len", 6);
        settle("t1_settle", 50);

        // Ack while idle is ignored.
        stray_ack = 1'b1;
        cyc(1);
        stray_ack = 1'b0;
        cyc(2);
        chk("stray_st", 64'(ifc.st_do), 64'd0);

        // Zero command: accepted, no strobe, straight to gap.
        post(2, 4'b0000, 32'h55, 1);
        wait_rdy("t5_rdy_seen", 2);
        chk("t5_rdy", 64'(ifc.req_rdy_o), 64'b0100);
        chk("t5_en", 64'(ifc.tc_en_o), 64'd0);
        busy_len("t5_busy_len", 3);
        settle("t5_settle", 50);

        // Multi-bit command passes through; rr_ptr wraps back to 0.
        post(3, 4'b1100, 32'hC3, 1);
        wait_rdy("mb_rdy_seen", 3);
        chk("mb_cmd", 64'(ifc.tc_cmd_o), 64'b1100);
        settle("mb_settle", 50);

        // Round-robin among three requesters, req0 asking twice.
        base = gq.size();
        post(0, 4'b0010, 32'h10, 2);
        post(1, 4'b0010, 32'h11, 1);
        post(2, 4'b0010, 32'h12, 1);
        settle("t2_settle", 200);
        chk("t2_g0", 64'(gq_at(base)), 64'd0);
        chk("t2_g1", 64'(gq_at(base + 1)), 64'd1);
        chk("t2_g2", 64'(gq_at(base + 2)), 64'd2);
        chk("t2_g3", 64'(gq_at(base + 3)), 64'd0);

        // Ack timeout: flag rises ACK_TO cycles after entering the ack wait.
        ack_dly = 0;
        post(1, 4'b0010, 32'h44, 1);
        wait_rdy("t4_rdy_seen", 1);
        c = 0;
        while (ifc.st_do != 2'd2 && c < 10) begin cyc(1); c++; end
        c = 0;
        while (!ifc.err_to_o && c < 400) begin cyc(1); c++; end
        chk("t4_to_lat", 64'(c), 64'(ACK_TO));
        settle("t4_settle", 50);
        chk("t4_sticky", 64'(ifc.err_to_o), 64'd1);
        ifc.err_clr_i = 1'b1;
        cyc(1);
        ifc.err_clr_i = 1'b0;
        chk("t4_clr", 64'(ifc.err_to_o), 64'd0);
        // Clear held through a second timeout: the set still wins in that cycle.
        ifc.err_clr_i = 1'b1;
        post(1, 4'b0010, 32'h45, 1);
        c = 0;
        while (!ifc.err_to_o && c < 400) begin cyc(1); c++; end
        chk("t4_set_wins", 64'(ifc.err_to_o), 64'd1);
        cyc(1);
        chk("t4_clr_after", 64'(ifc.err_to_o), 64'd0);
        ifc.err_clr_i = 1'b0;
        settle("t4_settle2", 50);

        // Async reset while waiting for ack; pending requests re-arbitrated from rr_ptr=0.
        post(1, 4'b0010, 32'h61, 1);
        wait_rdy("t6_rdy_seen", 1);
        cyc(1);
        post(0, 4'b0010, 32'h60, 1);
        post(3, 4'b0010, 32'h63, 1);
        cyc(4);
        chk("t6_pre_st", 64'(ifc.st_do), 64'd2);
        rst_n = 1'b0;
        #1;
        chk("t6_async_st", 64'(ifc.st_do), 64'd0);
        chk("t6_async_busy", 64'(ifc.busy_o), 64'd0);
        chk("t6_async_dt", 64'(ifc.tc_dt_o), 64'd0);
        chk("t6_async_gid", 64'(ifc.grant_id_o), 64'd0);
        ack_dly = 3;
        cyc(2);
        base = gq.size();
        rst_n = 1'b1;
        settle("t6_settle", 100);
        chk("t6_first", 64'(gq_at(base)), 64'd0);
        chk("t6_second", 64'(gq_at(base + 1)), 64'd3);

        cyc(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1);
    end
endmodule
